// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB RX byte assembler.
package usb_rx_pkg;

    typedef enum logic [1:0] {IDLE, RECV, ERR} rx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/flex_stp_sr_rx.sv
// Serial-to-parallel shift register for the RX path; resets and clears to the idle line level.
module flex_stp_sr_rx
    import usb_rx_pkg::*;
#(
    parameter int unsigned NUM_BITS  = 8,
    parameter int unsigned SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_enable,
    input  logic                clear,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    logic [NUM_BITS-1:0] sr_q;
    logic [NUM_BITS-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = {NUM_BITS{IDLE_LEVEL}};
        end else if (shift_enable) begin
            sr_d = (SHIFT_MSB != 0) ? {sr_q[NUM_BITS-2:0], serial_in}
                                    : {serial_in, sr_q[NUM_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= {NUM_BITS{IDLE_LEVEL}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign parallel_out = sr_q;

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// RX byte assembler: drops stuffed bits, frames NUM_BITS-wide words between SYNC and EOP.
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int unsigned NUM_BITS  = 8,
    parameter int unsigned SHIFT_MSB = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                shift_strobe,
    input  logic                stuff_bit,
    input  logic                sync_clear,
    input  logic                eop,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                byte_valid,
    output logic [CNT_W-1:0]    byte_count,
    output logic                packet_done,
    output logic                framing_err,
    output logic                busy
);

    localparam int unsigned     BC_W     = $clog2(NUM_BITS + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(NUM_BITS - 1);

    rx_state_t           state_q, state_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;
    logic [NUM_BITS-1:0] rx_data_q, rx_data_d;
    logic                byte_valid_q, byte_valid_d;
    logic                packet_done_q, packet_done_d;
    logic                framing_err_q, framing_err_d;

    logic                accept;
    logic                sr_shift;
    logic                sr_clear;
    logic [NUM_BITS-1:0] sr_word;
    logic [NUM_BITS-1:0] next_word;

    flex_stp_sr_rx #(
        .NUM_BITS  (NUM_BITS),
        .SHIFT_MSB (SHIFT_MSB)
    ) u_sr (
        .clk          (clk),
        .rst          (rst),
        .shift_enable (sr_shift),
        .clear        (sr_clear),
        .serial_in    (serial_in),
        .parallel_out (sr_word)
    );

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_count_d  = byte_count_q;
        rx_data_d     = rx_data_q;
        byte_valid_d  = 1'b0;
        packet_done_d = 1'b0;
        framing_err_d = framing_err_q;
        sr_shift      = 1'b0;
        sr_clear      = 1'b0;
        accept        = shift_strobe & ~stuff_bit;
        // Word as it will look once the current bit lands; captured on the final bit.
        next_word     = (SHIFT_MSB != 0) ? {sr_word[NUM_BITS-2:0], serial_in}
                                         : {serial_in, sr_word[NUM_BITS-1:1]};

        if (sync_clear) begin
            state_d       = RECV;
            bit_cnt_d     = '0;
            byte_count_d  = '0;
            framing_err_d = 1'b0;
            sr_clear      = 1'b1;
        end else if (state_q == RECV) begin
            if (accept) begin
                sr_shift = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d    = '0;
                    rx_data_d    = next_word;
                    byte_valid_d = 1'b1;
                    if (byte_count_q != '1) begin
                        byte_count_d = byte_count_q + CNT_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                end
            end
            // EOP is judged after this cycle's bit has been counted.
            if (eop) begin
                if (bit_cnt_d == '0) begin
                    state_d       = IDLE;
                    packet_done_d = 1'b1;
                end else begin
                    state_d       = ERR;
                    framing_err_d = 1'b1;
                    bit_cnt_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            byte_count_q  <= '0;
            rx_data_q     <= {NUM_BITS{IDLE_LEVEL}};
            byte_valid_q  <= 1'b0;
            packet_done_q <= 1'b0;
            framing_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_count_q  <= byte_count_d;
            rx_data_q     <= rx_data_d;
            byte_valid_q  <= byte_valid_d;
            packet_done_q <= packet_done_d;
            framing_err_q <= framing_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign byte_valid  = byte_valid_q;
    assign byte_count  = byte_count_q;
    assign packet_done = packet_done_q;
    assign framing_err = framing_err_q;
    assign busy        = (state_q == RECV);

endmodule
